// File: rtl/cmd_frame_parser.sv
// Sync-word hunting command-frame parser: header capture, payload buffer,
// checksum check, one-hot channel routing and valid/ready frame hand-off.
module cmd_frame_parser #(
  parameter int          SYNC_BYTES = 4,
  parameter logic [31:0] SYNC_WORD  = 32'hAA995566,
  parameter int          MAX_LEN    = 16,
  parameter int          CKSUM_MODE = 0,
  parameter int          NCH        = 4,
  parameter int          TIMEOUT    = 4096,
  localparam int         AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           rx_valid,
  input  logic [7:0]     rx_data,
  output logic           frm_valid,
  input  logic           frm_ready,
  output logic [7:0]     frm_cmd,
  output logic [7:0]     frm_dev,
  output logic [7:0]     frm_len,
  output logic [NCH-1:0] frm_chan,
  input  logic [AW-1:0]  pay_addr,
  output logic [7:0]     pay_data,
  output logic           err_cksum,
  output logic           err_len,
  output logic           err_tmo,
  output logic [15:0]    good_cnt,
  output logic [15:0]    bad_cnt
);

  localparam int SW = SYNC_BYTES * 8;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] MAXL = 8'(MAX_LEN);
  localparam logic [SW-1:0] SYNC = SYNC_WORD[SW-1:0];

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_DEV,
    S_LEN,
    S_PAY,
    S_CKS,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_sync;
  logic [7:0]      r_acc;
  logic [7:0]      r_idx;
  logic [TW-1:0]   r_idle;
  logic            r_valid;
  logic [7:0]      r_cmd;
  logic [7:0]      r_dev;
  logic [7:0]      r_len;
  logic [NCH-1:0]  r_chan;
  logic [7:0]      r_pay;
  logic            r_err_cks;
  logic            r_err_len;
  logic            r_err_tmo;
  logic [15:0]     r_good;
  logic [15:0]     r_bad;
  logic [7:0]      r_buf [0:(1<<AW)-1];

  logic [SW-1:0]   w_sync_nx;
  logic            w_hit;
  logic [7:0]      w_acc_nx;
  logic            w_in_frame;
  logic            w_tmo;
  logic            w_buf_we;
  logic [NCH-1:0]  w_chan;

  if (SYNC_BYTES == 1) begin : g_s1
    assign w_sync_nx = rx_data;
  end else begin : g_sn
    assign w_sync_nx = {r_sync[SW-9:0], rx_data};
  end

  assign w_hit      = (w_sync_nx == SYNC);
  assign w_acc_nx   = (CKSUM_MODE != 0) ? (r_acc ^ rx_data)
                                        : (r_acc + rx_data);
  assign w_in_frame = (r_state == S_CMD) || (r_state == S_DEV) ||
                      (r_state == S_LEN) || (r_state == S_PAY) ||
                      (r_state == S_CKS);
  // Expiry takes priority over a byte landing in the same cycle.
  assign w_tmo      = w_in_frame && (r_idle == TLAST);
  assign w_buf_we   = rst_b && !w_tmo && rx_valid &&
                      (r_state == S_PAY);

  always_comb begin
    w_chan = '0;
    for (int i = 0; i < NCH; i++) begin
      w_chan[i] = (rx_data == 8'(i));
    end
  end

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_idx[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state   <= S_HUNT;
      r_sync    <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_idle    <= '0;
      r_valid   <= 1'b0;
      r_cmd     <= '0;
      r_dev     <= '0;
      r_len     <= '0;
      r_chan    <= '0;
      r_pay     <= '0;
      r_err_cks <= 1'b0;
      r_err_len <= 1'b0;
      r_err_tmo <= 1'b0;
      r_good    <= '0;
      r_bad     <= '0;
    end else begin
      r_err_cks <= 1'b0;
      r_err_len <= 1'b0;
      r_err_tmo <= 1'b0;
      r_pay     <= r_buf[pay_addr];
      if (!w_in_frame || rx_valid) r_idle <= '0;
      else                         r_idle <= r_idle + 1'b1;
      if (w_tmo) begin
        r_state   <= S_HUNT;
        r_idle    <= '0;
        r_err_tmo <= 1'b1;
        r_bad     <= sat16(r_bad);
      end else begin
        unique case (r_state)
          S_HUNT: if (rx_valid) begin
            if (w_hit) begin
              r_sync  <= '0;
              r_acc   <= '0;
              r_state <= S_CMD;
            end else begin
              r_sync  <= w_sync_nx;
            end
          end
          S_CMD: if (rx_valid) begin
            r_cmd   <= rx_data;
            r_acc   <= w_acc_nx;
            r_state <= S_DEV;
          end
          S_DEV: if (rx_valid) begin
            r_dev   <= rx_data;
            r_chan  <= w_chan;
            r_acc   <= w_acc_nx;
            r_state <= S_LEN;
          end
          S_LEN: if (rx_valid) begin
            if (rx_data > MAXL) begin
              r_err_len <= 1'b1;
              r_bad     <= sat16(r_bad);
              r_state   <= S_HUNT;
            end else begin
              r_len   <= rx_data;
              r_acc   <= w_acc_nx;
              r_idx   <= '0;
              r_state <= (rx_data == 8'd0) ? S_CKS : S_PAY;
            end
          end
          S_PAY: if (rx_valid) begin
            r_acc <= w_acc_nx;
            r_idx <= r_idx + 8'd1;
            if (r_idx == r_len - 8'd1) r_state <= S_CKS;
          end
          S_CKS: if (rx_valid) begin
            if (rx_data == r_acc) begin
              r_valid <= 1'b1;
              r_good  <= sat16(r_good);
              r_state <= S_HOLD;
            end else begin
              r_err_cks <= 1'b1;
              r_bad     <= sat16(r_bad);
              r_state   <= S_HUNT;
            end
          end
          S_HOLD: if (frm_ready) begin
            r_valid <= 1'b0;
            r_state <= S_HUNT;
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

  assign frm_valid = r_valid;
  assign frm_cmd   = r_cmd;
  assign frm_dev   = r_dev;
  assign frm_len   = r_len;
  assign frm_chan  = r_chan;
  assign pay_data  = r_pay;
  assign err_cksum = r_err_cks;
  assign err_len   = r_err_len;
  assign err_tmo   = r_err_tmo;
  assign good_cnt  = r_good;
  assign bad_cnt   = r_bad;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: default instance plus a
// 2-byte-sync XOR-checksum instance.
module tb_cmd_frame_parser;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_b;
  logic       rv, rv2;
  logic [7:0] rd, rd2;
  logic       fr, fr2;
  logic [3:0] pa, pa2;

  logic       fv, fv2;
  logic [7:0] cmd, dev, len, pd;
  logic [7:0] cmd2, dev2, len2, pd2;
  logic [3:0] ch, ch2;
  logic       ecks, elen, etmo;
  logic       ecks2, elen2, etmo2;
  logic [15:0] gc, bc, gc2, bc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmd_frame_parser u_dut (
    .clk(clk), .rst_b(rst_b),
    .rx_valid(rv), .rx_data(rd),
    .frm_valid(fv), .frm_ready(fr),
    .frm_cmd(cmd), .frm_dev(dev), .frm_len(len),
    .frm_chan(ch), .pay_addr(pa), .pay_data(pd),
    .err_cksum(ecks), .err_len(elen), .err_tmo(etmo),
    .good_cnt(gc), .bad_cnt(bc)
  );

  cmd_frame_parser #(
    .SYNC_BYTES(2), .SYNC_WORD(32'h0000_5566), .CKSUM_MODE(1)
  ) u_dx (
    .clk(clk), .rst_b(rst_b),
    .rx_valid(rv2), .rx_data(rd2),
    .frm_valid(fv2), .frm_ready(fr2),
    .frm_cmd(cmd2), .frm_dev(dev2), .frm_len(len2),
    .frm_chan(ch2), .pay_addr(pa2), .pay_data(pd2),
    .err_cksum(ecks2), .err_len(elen2), .err_tmo(etmo2),
    .good_cnt(gc2), .bad_cnt(bc2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int sel, input bq_t q);
    foreach (q[i]) begin
      if (sel == 0) begin rv = 1'b1; rd = q[i]; end
      else begin rv2 = 1'b1; rd2 = q[i]; end
      @(negedge clk);
    end
    rv = 1'b0;
    rv2 = 1'b0;
  endtask

  task automatic rd_pay(input bq_t exp);
    foreach (exp[i]) begin
      pa = 4'(i);
      @(negedge clk);
      chk($sformatf("pay%0d", i), pd, exp[i]);
    end
  endtask

  task automatic accept();
    fr = 1'b1;
    @(negedge clk);
    chk("xfer", fv, 0);
    fr = 1'b0;
  endtask

  bq_t q, p;
  int  n, held;

  initial begin
    rst_b = 1'b0;
    rv = 0; rv2 = 0; rd = 0; rd2 = 0;
    fr = 0; fr2 = 0; pa = 0; pa2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", fv, 0);
    chk("rst_good", gc, 0);
    chk("rst_bad", bc, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_chan", ch, 0);
    chk("rst_pay", pd, 0);
    rst_b = 1'b1;
    @(negedge clk);

    // frame 1
    q = '{8'hAA, 8'h99, 8'h55, 8'h66, 8'h02, 8'h00, 8'h03,
          8'h00, 8'h00, 8'h20, 8'h25};
    send(0, q);
    chk("f1_valid", fv, 1);
    chk("f1_cmd", cmd, 8'h02);
    chk("f1_dev", dev, 8'h00);
    chk("f1_len", len, 8'h03);
    chk("f1_chan", ch, 4'b0001);
    chk("f1_good", gc, 1);
    p = '{8'h00, 8'h00, 8'h20};
    rd_pay(p);
    accept();

    // frame 2, consumer stalls 20 cycles
    q = '{8'hAA, 8'h99, 8'h55, 8'h66, 8'h00, 8'h33, 8'h08,
          8'h00, 8'h34, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h73};
    send(0, q);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fv && cmd == 8'h00 && dev == 8'h33 && len == 8'h08)
        held++;
    end
    chk("f2_held", held, 20);
    chk("f2_chan", ch, 4'b0000);
    chk("f2_good", gc, 2);
    p = '{8'h00, 8'h34, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rd_pay(p);
    chk("f2_still", fv, 1);
    accept();

    // bad checksum then good frame back-to-back
    q = '{8'hAA, 8'h99, 8'h55, 8'h66, 8'h01, 8'h33, 8'h04,
          8'h00, 8'h34, 8'h77, 8'hF0, 8'hD2};
    send(0, q);
    chk("f3_ecks", ecks, 1);
    chk("f3_valid", fv, 0);
    chk("f3_bad", bc, 1);
    q = '{8'hAA, 8'h99, 8'h55, 8'h66, 8'h01, 8'h33, 8'h04,
          8'h00, 8'h34, 8'h77, 8'hF0, 8'hD3};
    send(0, q);
    chk("f3_ecks_clr", ecks, 0);
    chk("f3b_valid", fv, 1);
    chk("f3b_cmd", cmd, 8'h01);
    chk("f3b_good", gc, 3);
    accept();

    // overlapping sync
    q = '{8'hAA, 8'hAA, 8'h99, 8'h55, 8'h66, 8'h02, 8'h00,
          8'h03, 8'h00, 8'h00, 8'h20, 8'h25};
    send(0, q);
    chk("f4_valid", fv, 1);
    chk("f4_good", gc, 4);
    accept();

    // oversize length
    q = '{8'hAA, 8'h99, 8'h55, 8'h66, 8'h02, 8'h00, 8'h11};
    send(0, q);
    chk("len_err", elen, 1);
    chk("len_bad", bc, 2);
    @(negedge clk);
    chk("len_pulse1", elen, 0);
    q = '{8'hAA, 8'h99, 8'h55, 8'h66, 8'h02, 8'h00, 8'h00, 8'h02};
    send(0, q);
    chk("len0_valid", fv, 1);
    chk("len0_good", gc, 5);
    accept();

    // timeout after dev byte
    q = '{8'hAA, 8'h99, 8'h55, 8'h66, 8'h02, 8'h00};
    send(0, q);
    n = 0;
    for (int i = 1; i <= 4096 + 20; i++) begin
      @(negedge clk);
      if (etmo) begin n = i; break; end
    end
    chk("tmo_cyc", n, 4096);
    chk("tmo_bad", bc, 3);
    @(negedge clk);
    chk("tmo_pulse1", etmo, 0);
    q = '{8'hAA, 8'h99, 8'h55, 8'h66, 8'h02, 8'h00, 8'h03,
          8'h00, 8'h00, 8'h20, 8'h25};
    send(0, q);
    chk("tmo_next", gc, 6);
    accept();

    // reset mid-payload
    q = '{8'hAA, 8'h99, 8'h55, 8'h66, 8'h05, 8'h01, 8'h03, 8'h00};
    send(0, q);
    rst_b = 1'b0;
    @(negedge clk);
    chk("mr_valid", fv, 0);
    chk("mr_good", gc, 0);
    chk("mr_bad", bc, 0);
    chk("mr_cmd", cmd, 0);
    chk("mr_dev", dev, 0);
    chk("mr_len", len, 0);
    chk("mr_pay", pd, 0);
    rst_b = 1'b1;
    q = '{8'hAA, 8'h99, 8'h55, 8'h66, 8'h02, 8'h00, 8'h03,
          8'h00, 8'h00, 8'h20, 8'h25};
    send(0, q);
    chk("mr_next", fv, 1);
    chk("mr_good1", gc, 1);
    accept();

    // XOR checksum, 2-byte sync
    q = '{8'h55, 8'h66, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00,
          8'h20, 8'h21};
    send(1, q);
    chk("x_valid", fv2, 1);
    chk("x_cmd", cmd2, 8'h02);
    chk("x_good", gc2, 1);
    fr2 = 1'b1;
    @(negedge clk);
    chk("x_xfer", fv2, 0);
    fr2 = 1'b0;
    q = '{8'h55, 8'h66, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00,
          8'h20, 8'h25};
    send(1, q);
    chk("x_ecks", ecks2, 1);
    chk("x_nvalid", fv2, 0);
    chk("x_bad", bc2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
